// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR pseudo-random source with a valid/ready output.
//
// Each accepted word (rnd_valid & rnd_ready) advances the LFSR by STEPS single-bit
// shifts when en is high. If en is low at that point, the source parks in STALL until
// en returns. A zero seed is replaced by DEFAULT_SEED, so the all-zero lock-up state
// is never reached.
//
// Parameters:
//   WIDTH        LFSR width in bits (3..32)
//   TAPS         feedback mask, bit WIDTH-1 set
//   STEPS        single-bit shifts per advance (1..WIDTH)
//   DEFAULT_SEED nonzero substitute for a zero seed
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         load seed (overrides everything else)
//   seed         seed value sampled when load=1
//   en           permits the LFSR to advance
//   rnd_ready    consumer accepts rnd this cycle
//   rnd_valid    rnd holds a fresh value
//   rnd          current LFSR state
//   seed_fixed   one-cycle pulse: zero seed replaced by DEFAULT_SEED
//   period_wrap  one-cycle pulse: an advance returned the state to the loaded seed
module lfsr_prng #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd,
  output logic             seed_fixed,
  output logic             period_wrap
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GEN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             seed_fixed_q, seed_fixed_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] adv_val;
  logic [WIDTH-1:0] seed_eff;

  // STEPS single shifts unrolled into one combinational advance.
  always_comb begin
    adv_val = rnd_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv_val = {adv_val[WIDTH-2:0], ^(adv_val & TAPS)};
    end
  end

  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    seed_d       = seed_q;
    seed_fixed_d = 1'b0;
    wrap_d       = 1'b0;
    if (load) begin
      // A same-cycle transfer is treated as consumed; the new seed replaces it, no advance.
      rnd_d        = seed_eff;
      seed_d       = seed_eff;
      seed_fixed_d = (seed == '0);
      state_d      = GEN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        GEN: begin
          if (rnd_ready) begin
            if (en) begin
              rnd_d  = adv_val;
              wrap_d = (adv_val == seed_q);
            end else begin
              state_d = STALL;
            end
          end
        end
        STALL: begin
          if (en) begin
            rnd_d   = adv_val;
            wrap_d  = (adv_val == seed_q);
            state_d = GEN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      seed_q       <= '0;
      seed_fixed_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      seed_q       <= seed_d;
      seed_fixed_q <= seed_fixed_d;
      wrap_q       <= wrap_d;
    end
  end

  assign rnd_valid   = (state_q == GEN);
  assign rnd         = rnd_q;
  assign seed_fixed  = seed_fixed_q;
  assign period_wrap = wrap_q;

endmodule
